// File: rtl/rv32_pkg.sv
// RV32 shared types: opcodes, funct3 codes, immediate formats and the decoded packet.
// The imm_gen helper builds the sign-extended immediate for a given format.
package rv32_pkg;

   localparam int PKT_XLEN = 32;

   typedef enum logic [6:0] {
      OPC_LOAD     = 7'b0000011,
      OPC_MISC_MEM = 7'b0001111,
      OPC_OP_IMM   = 7'b0010011,
      OPC_AUIPC    = 7'b0010111,
      OPC_STORE    = 7'b0100011,
      OPC_OP       = 7'b0110011,
      OPC_LUI      = 7'b0110111,
      OPC_BRANCH   = 7'b1100011,
      OPC_JALR     = 7'b1100111,
      OPC_JAL      = 7'b1101111,
      OPC_SYSTEM   = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      F3_ADD_SUB = 3'd0, F3_SLL  = 3'd1, F3_SLT     = 3'd2, F3_SLTU = 3'd3,
      F3_XOR     = 3'd4, F3_SRL_SRA = 3'd5, F3_OR   = 3'd6, F3_AND  = 3'd7
   } funct3_t;

   typedef enum logic [2:0] {
      FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
   } imm_fmt_t;

   typedef struct packed {
      logic [6:0]          opcode;
      logic [4:0]          rd;
      logic [2:0]          funct3;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [6:0]          funct7;
      imm_fmt_t            fmt;
      logic [PKT_XLEN-1:0] imm;
      logic [PKT_XLEN-1:0] pc;
      logic                illegal;
   } dec_pkt_t;

   function automatic logic [PKT_XLEN-1:0] imm_gen(input logic [31:0] inst, input imm_fmt_t fmt);
      logic [PKT_XLEN-1:0] imm;
      case (fmt)
         FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
         FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U:   imm = {inst[31:12], 12'b0};
         FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/dec_fifo.sv
// Circular instruction buffer of DEPTH {inst, pc} entries with occupancy count.
// Storage is not reset; only pointers and count carry reset state.
module dec_fifo #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [31:0]              wr_inst,
   input  logic [XLEN-1:0]          wr_pc,
   output logic [31:0]              rd_inst,
   output logic [XLEN-1:0]          rd_pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]     mem_inst [DEPTH];
   logic [XLEN-1:0] mem_pc   [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_inst[wr_ptr] <= wr_inst;
         mem_pc[wr_ptr]   <= wr_pc;
      end
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   assign rd_inst = mem_inst[rd_ptr];
   assign rd_pc   = mem_pc[rd_ptr];
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage: buffer -> decode -> output register, valid/ready on both sides.
// Optional macro DECODE_ILLEGAL_CHECK_EN adds encoding checks to out_illegal.
module decode_stage
   import rv32_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_inst,
   input  logic [XLEN-1:0]        in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [6:0]             out_opcode,
   output logic [4:0]             out_rd,
   output logic [4:0]             out_rs1,
   output logic [4:0]             out_rs2,
   output logic [2:0]             out_funct3,
   output logic [6:0]             out_funct7,
   output logic [2:0]             out_fmt,
   output logic [XLEN-1:0]        out_imm,
   output logic [XLEN-1:0]        out_pc,
   output logic                   out_illegal,
   output logic [$clog2(DEPTH):0] count
);
   logic            full, empty, push, pop, in_fire, load_en;
   logic [31:0]     head_inst, src_inst;
   logic [XLEN-1:0] head_pc, src_pc;
   dec_pkt_t        pkt, out_q;
   logic            out_valid_q;

   assign in_ready = !full;
   assign in_fire  = in_valid && in_ready;
   assign load_en  = !out_valid_q || out_ready;
   // An empty buffer with a free output register lets the input bypass the buffer
   assign pop      = load_en && !empty && !flush;
   assign push     = in_fire && !flush && !(empty && load_en);

   dec_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
      .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .pop(pop),
      .wr_inst(in_inst), .wr_pc(in_pc), .rd_inst(head_inst), .rd_pc(head_pc),
      .count(count), .full(full), .empty(empty)
   );

   assign src_inst = empty ? in_inst : head_inst;
   assign src_pc   = empty ? in_pc   : head_pc;

   always_comb begin
      pkt         = '0;
      pkt.opcode  = src_inst[6:0];
      pkt.rd      = src_inst[11:7];
      pkt.funct3  = src_inst[14:12];
      pkt.rs1     = src_inst[19:15];
      pkt.rs2     = src_inst[24:20];
      pkt.funct7  = src_inst[31:25];
      pkt.pc      = src_pc;
      pkt.fmt     = FMT_R;
      pkt.illegal = 1'b0;
      case (src_inst[6:0])
         OPC_LUI, OPC_AUIPC:                                   pkt.fmt = FMT_U;
         OPC_JAL:                                              pkt.fmt = FMT_J;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: pkt.fmt = FMT_I;
         OPC_STORE:                                            pkt.fmt = FMT_S;
         OPC_BRANCH:                                           pkt.fmt = FMT_B;
         OPC_OP:                                               pkt.fmt = FMT_R;
         default:                                              pkt.illegal = 1'b1;
      endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
      if (src_inst[1:0] != 2'b11) pkt.illegal = 1'b1;
      if (src_inst[6:0] == OPC_OP) begin
         if (pkt.funct7 != 7'h00 && pkt.funct7 != 7'h20) pkt.illegal = 1'b1;
         if (pkt.funct7 == 7'h20 && pkt.funct3 != F3_ADD_SUB && pkt.funct3 != F3_SRL_SRA)
            pkt.illegal = 1'b1;
      end
      if (src_inst[6:0] == OPC_OP_IMM) begin
         if (pkt.funct3 == F3_SLL && pkt.funct7 != 7'h00) pkt.illegal = 1'b1;
         if (pkt.funct3 == F3_SRL_SRA && pkt.funct7 != 7'h00 && pkt.funct7 != 7'h20)
            pkt.illegal = 1'b1;
      end
`endif
      pkt.imm = imm_gen(src_inst, pkt.fmt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (load_en) begin
         if (!empty || in_fire) begin
            out_q       <= pkt;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_opcode  = out_q.opcode;
   assign out_rd      = out_q.rd;
   assign out_rs1     = out_q.rs1;
   assign out_rs2     = out_q.rs2;
   assign out_funct3  = out_q.funct3;
   assign out_funct7  = out_q.funct7;
   assign out_fmt     = out_q.fmt;
   assign out_imm     = out_q.imm;
   assign out_pc      = out_q.pc;
   assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed spec cases plus randomized traffic against a queue model.
// Honours DECODE_ILLEGAL_CHECK_EN when computing expected illegal flags.
module tb_decode_stage;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic            in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0]     in_inst = '0;
   logic [XLEN-1:0] in_pc = '0;
   logic            in_ready, out_valid, out_illegal;
   logic [6:0]      out_opcode, out_funct7;
   logic [4:0]      out_rd, out_rs1, out_rs2;
   logic [2:0]      out_funct3, out_fmt;
   logic [XLEN-1:0] out_imm, out_pc;
   logic [CW-1:0]   count;

   int n_chk = 0, n_fail = 0;

   typedef struct packed {
      logic [6:0] opc; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
      logic [2:0] f3; logic [6:0] f7; logic [2:0] fmt; logic [31:0] imm; logic ill;
   } exp_t;
   typedef struct packed { logic [31:0] inst; logic [31:0] pc; } ent_t;

   ent_t q[$];
   logic [6:0] opcs [0:10] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                               7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

   decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_funct3(out_funct3), .out_funct7(out_funct7), .out_fmt(out_fmt),
      .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal), .count(count)
   );

   always #5 clk = ~clk;

   // Format codes: R=0 I=1 S=2 B=3 U=4 J=5
   function automatic exp_t ref_dec(input logic [31:0] w);
      exp_t e;
      int   s;
      s     = w;
      e.opc = w[6:0];  e.rd = w[11:7];  e.f3 = w[14:12];
      e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f7 = w[31:25];
      e.ill = 1'b0;
      case (w[6:0])
         7'h37, 7'h17:                      e.fmt = 3'd4;
         7'h6F:                             e.fmt = 3'd5;
         7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: e.fmt = 3'd1;
         7'h23:                             e.fmt = 3'd2;
         7'h63:                             e.fmt = 3'd3;
         7'h33:                             e.fmt = 3'd0;
         default: begin e.fmt = 3'd0; e.ill = 1'b1; end
      endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
      if (w[1:0] != 2'b11) e.ill = 1'b1;
      if (w[6:0] == 7'h33 && !(e.f7 inside {7'h00, 7'h20})) e.ill = 1'b1;
      if (w[6:0] == 7'h33 && e.f7 == 7'h20 && !(e.f3 inside {3'd0, 3'd5})) e.ill = 1'b1;
      if (w[6:0] == 7'h13 && e.f3 == 3'd1 && e.f7 != 7'h00) e.ill = 1'b1;
      if (w[6:0] == 7'h13 && e.f3 == 3'd5 && !(e.f7 inside {7'h00, 7'h20})) e.ill = 1'b1;
`endif
      case (e.fmt)
         3'd1: e.imm = s >>> 20;
         3'd2: e.imm = ((s >>> 25) <<< 5) | int'(w[11:7]);
         3'd3: e.imm = ((s >>> 31) <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5)
                       | (int'(w[11:8]) << 1);
         3'd4: e.imm = w & 32'hFFFF_F000;
         3'd5: e.imm = ((s >>> 31) <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11)
                       | (int'(w[30:21]) << 1);
         default: e.imm = 32'd0;
      endcase
      return e;
   endfunction

   function automatic exp_t act_pkt();
      exp_t a;
      a = '{out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_fmt, out_imm, out_illegal};
      return a;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic send_one(input logic [31:0] w, input logic [31:0] pc);
      in_valid = 1'b1; in_inst = w; in_pc = pc;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if ({out_valid, out_illegal, count, in_ready} !== {1'b0, 1'b0, CW'(0), 1'b1}) begin
         n_fail++;
         $display("FAIL reset_ctrl: got v=%b ill=%b cnt=%0d rdy=%b, want 0 0 0 1",
                  out_valid, out_illegal, count, in_ready);
      end
      n_chk++;
      if ({out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_fmt, out_imm, out_pc} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got imm=%h pc=%h opc=%h, want all zero", out_imm, out_pc, out_opcode);
      end
      #1 rst_n = 1'b1;
   endtask

   task automatic test_decode();
      exp_t a;
      do_reset();
      out_ready = 1'b1;
      send_one(32'h0050_0093, 32'h100);
      a = act_pkt();
      n_chk++;
      if (!out_valid || a.fmt !== 3'd1 || a.rd !== 5'd1 || a.rs1 !== 5'd0 || a.imm !== 32'h5
          || out_pc !== 32'h100 || a.ill !== 1'b0) begin
         n_fail++;
         $display("FAIL addi: got v=%b fmt=%0d rd=%0d rs1=%0d imm=%h pc=%h ill=%b, want 1 1 1 0 00000005 00000100 0",
                  out_valid, a.fmt, a.rd, a.rs1, a.imm, out_pc, a.ill);
      end
      send_one(32'hFE00_0EE3, 32'h104);
      n_chk++;
      if (!out_valid || out_fmt !== 3'd3 || out_imm !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL beq: got v=%b fmt=%0d imm=%h, want 1 3 fffffffc", out_valid, out_fmt, out_imm);
      end
      send_one(32'h1234_52B7, 32'h108);
      n_chk++;
      if (!out_valid || out_fmt !== 3'd4 || out_rd !== 5'd5 || out_imm !== 32'h1234_5000) begin
         n_fail++;
         $display("FAIL lui: got v=%b fmt=%0d rd=%0d imm=%h, want 1 4 5 12345000",
                  out_valid, out_fmt, out_rd, out_imm);
      end
      send_one(32'h0000_007F, 32'h10C);
      n_chk++;
      if (!out_valid || out_illegal !== 1'b1 || out_imm !== 32'h0) begin
         n_fail++;
         $display("FAIL bad_opcode: got v=%b ill=%b imm=%h, want 1 1 00000000", out_valid, out_illegal, out_imm);
      end
      send_one(32'h4000_1033, 32'h110);
      n_chk++;
`ifdef DECODE_ILLEGAL_CHECK_EN
      if (out_illegal !== 1'b1) begin
         n_fail++;
         $display("FAIL f7_20_sll: got ill=%b, want 1", out_illegal);
      end
`else
      if (out_illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL f7_20_sll: got ill=%b, want 0", out_illegal);
      end
`endif
      // store and jal cover the remaining immediate shapes
      send_one(32'hFE11_2E23, 32'h114);
      n_chk++;
      if (out_fmt !== 3'd2 || out_imm !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL sw: got fmt=%0d imm=%h, want 2 fffffffc", out_fmt, out_imm);
      end
      send_one(32'h8000_00EF, 32'h118);
      n_chk++;
      if (out_fmt !== 3'd5 || out_imm !== 32'hFFF0_0000 || out_rd !== 5'd1) begin
         n_fail++;
         $display("FAIL jal: got fmt=%0d imm=%h rd=%0d, want 5 fff00000 1", out_fmt, out_imm, out_rd);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_inst = 32'h13 | (32'(i) << 7); in_pc = 32'h200 + 32'(4*i);
         n_chk++;
         if (in_ready !== (i < 5)) begin
            n_fail++;
            $display("FAIL bp_in_ready[%0d]: got %b, want %b", i, in_ready, (i < 5));
         end
         cyc();
      end
      in_valid = 1'b0;
      n_chk++;
      if (count !== CW'(4) || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_full: got cnt=%0d v=%b, want 4 1", count, out_valid);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         n_chk++;
         if (!out_valid || out_pc !== 32'h200 + 32'(4*k) || out_rd !== 5'(k)) begin
            n_fail++;
            $display("FAIL bp_order[%0d]: got v=%b pc=%h rd=%0d, want 1 %h %0d",
                     k, out_valid, out_pc, out_rd, 32'h200 + 32'(4*k), k);
         end
         cyc();
      end
      n_chk++;
      if (out_valid !== 1'b0 || count !== CW'(0)) begin
         n_fail++;
         $display("FAIL bp_drained: got v=%b cnt=%0d, want 0 0", out_valid, count);
      end
   endtask

   task automatic test_flush();
      int seen;
      do_reset();
      for (int i = 0; i < 4; i++) send_one(32'h13, 32'h300 + 32'(4*i));
      n_chk++;
      if (count !== CW'(3) || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_pre: got cnt=%0d v=%b, want 3 1", count, out_valid);
      end
      flush = 1'b1; in_valid = 1'b1; in_inst = 32'h13; in_pc = 32'hDEAD;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      n_chk++;
      if (out_valid !== 1'b0 || count !== CW'(0)) begin
         n_fail++;
         $display("FAIL flush_clear: got v=%b cnt=%0d, want 0 0", out_valid, count);
      end
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (out_valid) seen++;
         cyc();
      end
      n_chk++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL flush_ghost: got %0d stale packets, want 0", seen);
      end
      send_one(32'h0070_0393, 32'h500);
      n_chk++;
      if (!out_valid || out_pc !== 32'h500 || out_rd !== 5'd7) begin
         n_fail++;
         $display("FAIL flush_after: got v=%b pc=%h rd=%0d, want 1 00000500 7", out_valid, out_pc, out_rd);
      end
   endtask

   task automatic test_random();
      int   errs;
      bit   fin, fout;
      ent_t e;
      exp_t x;
      do_reset();
      q.delete();
      errs = 0;
      for (int c = 0; c < 400; c++) begin
         n_chk++;
         if (out_valid !== (q.size() != 0) || (int'(count) + int'(out_valid)) != q.size()
             || in_ready !== (q.size() <= DEPTH)) begin
            n_fail++; errs++;
            if (errs < 10)
               $display("FAIL rand_occ[%0d]: got v=%b cnt=%0d rdy=%b, want in-flight %0d",
                        c, out_valid, count, in_ready, q.size());
         end
         if (out_valid && q.size() != 0) begin
            x = ref_dec(q[0].inst);
            n_chk++;
            if (act_pkt() !== x || out_pc !== q[0].pc) begin
               n_fail++; errs++;
               if (errs < 10)
                  $display("FAIL rand_pkt[%0d]: got %h pc=%h, want %h pc=%h",
                           c, act_pkt(), out_pc, x, q[0].pc);
            end
         end
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_inst   = $urandom;
         if ($urandom_range(0, 7) != 0) in_inst[6:0] = opcs[$urandom_range(0, 10)];
         in_pc     = 32'h1000 + 32'(4*c);
         #1;
         fin  = in_valid && in_ready;
         fout = out_valid && out_ready;
         if (fout && q.size() != 0) void'(q.pop_front());
         if (fin) begin e.inst = in_inst; e.pc = in_pc; q.push_back(e); end
         cyc();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 3; i++) send_one(32'h13, 32'h600 + 32'(4*i));
      n_chk++;
      if (count !== CW'(2) || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_pre: got cnt=%0d v=%b, want 2 1", count, out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || count !== CW'(0) || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_now: got v=%b cnt=%0d rdy=%b, want 0 0 1", out_valid, count, in_ready);
      end
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      cyc();
      n_chk++;
      if (out_valid !== 1'b0 || count !== CW'(0)) begin
         n_fail++;
         $display("FAIL areset_after: got v=%b cnt=%0d, want 0 0", out_valid, count);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_backpressure();
      test_flush();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32 decode stage with a valid/ready handshake.
- Accepts fetched instruction words with their PC into a small instruction buffer.
- Splits each word into fields, classifies its format and sign-extends the immediate to XLEN bits.
- Presents the decoded result from a pipeline register to the issue/execute stage.
- Sits between fetch and execute; supersedes the purely combinational field splitter.

Parameters:
XLEN, 32, datapath width of imm and pc outputs (32 only in this generation; sized for growth).
DEPTH, 4, instruction buffer entries; power of two, >= 2.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous flush (branch redirect); drops all buffered and output contents.
in_valid  in  1  fetch offers an instruction.
in_ready  out  1  buffer can accept; equals !full.
in_inst  in  32  instruction word.
in_pc  in  XLEN  instruction address.
out_valid  out  1  decoded packet valid.
out_ready  in  1  consumer accepts the packet.
out_opcode  out  7  rv32_pkg::opcode_t.
out_rd, out_rs1, out_rs2  out  5 each  register indices.
out_funct3  out  3  rv32_pkg::funct3_t.
out_funct7  out  7  inst[31:25].
out_fmt  out  3  rv32_pkg::imm_fmt_t (R/I/S/B/U/J).
out_imm  out  XLEN  sign-extended immediate.
out_pc  out  XLEN  PC of the decoded instruction.
out_illegal  out  1  unrecognised opcode.
count  out  $clog2(DEPTH)+1  buffer occupancy.

Behaviour:
- Reset: out_valid=0, out_illegal=0, count=0, in_ready=1. All out_* data fields =0. Buffer pointers =0.
- Input transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- Output register loads when it is empty or being drained in the same cycle.
  - Source is the buffer head if the buffer is non-empty.
  - Otherwise the input is bypassed straight into the register.
  - Latency: accept at edge N, visible on out_* after edge N (i.e. one cycle) when buffer and register are empty.
- Ordering: strict FIFO.
- Capacity: DEPTH entries plus the output register, i.e. DEPTH+1 instructions in flight.
- Full buffer: in_ready=0. Simultaneous pop and push on a full buffer is allowed only next cycle; in_ready is registered-free, so in_ready = !full is combinational on the current count.
- Pointers: wrap modulo DEPTH. count tracks entries, 0..DEPTH.
- Output holds stable while out_valid && !out_ready.
- flush: clears pointers, count=0, out_valid=0 at the next edge. Any concurrent input transfer is discarded; in_ready stays as computed.
- Decode of the word entering the output register:
  - opcode/rd/funct3/rs1/rs2/funct7 take their standard bit positions.
  - fmt is selected by opcode:
    - LUI, AUIPC -> U
    - JAL -> J
    - JALR, LOAD, OP_IMM, MISC_MEM, SYSTEM -> I
    - STORE -> S
    - BRANCH -> B
    - OP -> R
    - any other opcode -> R with illegal=1
  - imm by format:
    - I: sext(inst[31:20])
    - S: sext({inst[31:25],inst[11:7]})
    - B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
    - U: {inst[31:12],12'b0}
    - J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
    - R: 0
- Reset mid-operation: asynchronous. All state returns to reset values immediately; in-flight instructions are lost.

Optional Feature:
DECODE_ILLEGAL_CHECK_EN.
- Defined: out_illegal also asserts for:
  - inst[1:0] != 2'b11
  - OP with funct7 not in {0x00, 0x20}
  - funct7=0x20 with funct3 not in {ADD/SUB, SRL/SRA}
  - OP_IMM shift with an invalid funct7
- Undefined: out_illegal asserts only on an unrecognised opcode.

Decomposition:
- rv32_pkg additions:
  - imm_fmt_t enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J)
  - dec_pkt_t packed struct holding all out_* fields
  - function imm_gen(inst, fmt)
- Existing opcode_t and funct3_t are reused.
- One sub-module: dec_fifo (parametrised DEPTH x {inst, pc} circular buffer with count, push, pop, flush).
- decode_stage instantiates dec_fifo plus the decode logic and the output register.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093, pc 0x100) with out_ready=1 -> after one edge: out_valid=1, fmt=I, rd=1, rs1=0, imm=0x00000005, pc=0x100, illegal=0.
- BEQ x0,x0,-4 (0xFE000EE3) -> fmt=B, imm=0xFFFFFFFC. LUI x5,0x12345 (0x123452B7) -> fmt=U, rd=5, imm=0x12345000.
- Backpressure, DEPTH=4, out_ready=0, push 6 sequential words:
  - first 5 accepted, in_ready=0 on the 6th, count=4
  - raise out_ready: packets emerge in push order, one per cycle
- Flush with count=3 and out_valid=1: next cycle out_valid=0, count=0. A word offered in the flush cycle never appears.
- Word 0x0000007F -> illegal=1, imm=0. With DECODE_ILLEGAL_CHECK_EN: 0x40001033 (funct7=0x20, funct3=1) -> illegal=1; without the macro -> illegal=0.
- Assert rst_n low for part of a cycle while count=2 -> out_valid and count drop to 0 immediately without a clock edge.
